oddeven_sort_engine: RTL and testbench
======================================

# oddeven_sort_engine

Parametrised, handshaked sorting engine that sorts `N` unsigned `WIDTH`-bit elements with odd-even transposition (parallel bubble sort), one compare-swap phase per clock. It adds runtime ascending/descending selection, start/done handshaking, early termination once the array is stable, and a phase-count readout for profiling. It is the drop-in sorting stage for the datapath wherever a fixed five-input sorter is too narrow or too shallow.

## Interface
- `WIDTH`, 8, element width in bits (≥1)
- `N`, 5, element count (≥2)
- `PW`, `$clog2(N+1)`, width of `phases` (derived, not overridden)

- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  request; sampled only while `busy`=0
- `descending`  input  1  sort order, latched with `start`: 0 = ascending, 1 = descending
- `in_data`  input  N*WIDTH  element i at bits [i*WIDTH +: WIDTH], captured with `start`
- `busy`  output  1  high from the cycle after accepted `start` through the `done` cycle
- `done`  output  1  one-cycle pulse when `out_data` is updated
- `out_data`  output  N*WIDTH  sorted result, element i at [i*WIDTH +: WIDTH]; holds until the next `done`
- `phases`  output  PW  number of phases executed for the last result

## Operation
- FSM states: IDLE, SORT, FINISH.
- IDLE: on `start`=1, load internal array `a` from `in_data`, latch `descending`, clear `pcnt` and `prev_clean`, go to SORT.
- SORT, one phase per cycle; the phase parity is even when `pcnt` is even:
  - Even phase: compare pairs (0,1), (2,3), and so on.
  - Odd phase: compare pairs (1,2), (3,4), and so on.
  - Ascending: swap when a[i] > a[i+1]. Descending: swap when a[i] < a[i+1].
  - Equal elements never swap, so the sort is stable.
  - `clean` = no swap this phase. Increment `pcnt`. Set `prev_clean` to `clean`.
- Exit SORT to FINISH after the phase in which either:
  - `clean` and `prev_clean` are both 1, or
  - `pcnt` reaches N.
- FINISH:
  - Write `a` to `out_data` and `pcnt` to `phases`.
  - Pulse `done`.
  - Return to IDLE.
- Correctness: N phases always suffice, so the result is fully sorted regardless of the early-exit path.
- Comparisons are unsigned and full `WIDTH`. No overflow is possible because the block only compares and swaps.
- `start` while `busy`=1 is ignored: no queueing and no effect on the running sort. `in_data` and `descending` may change freely after acceptance.

## Timing
- Reset values: `busy`=0, `done`=0, `out_data`=0, `phases`=0, FSM in IDLE, internal array and counters cleared.
- `rst` mid-sort aborts the operation. No `done` pulse is produced, and `out_data`/`phases` return to 0.
- Let `start` be accepted at edge 0 and let k be the number of phases (2 ≤ k ≤ N):
  - Phases occupy cycles 1..k.
  - `done`=1 and the new `out_data`/`phases` are visible in cycle k+1.
  - `busy`=1 in cycles 1..k+1.
- Minimum latency is 3 cycles (already sorted). Maximum latency is N+1 cycles.
- `start` may be asserted in the cycle after `done`, giving a back-to-back throughput of one sort per k+2 cycles.
- `rst` and `start` asserted in the same cycle: `rst` wins and `start` is dropped.

## Test plan
- N=5, WIDTH=8, ascending, in={16,14,15,17,12} (element 0 first) -> out={12,14,15,16,17}, `phases`=5, `done` 6 cycles after `start`.
- Same input with `descending`=1 -> out={17,16,15,14,12}, `done` pulse exactly 1 cycle wide, `busy` deasserts the cycle after `done`.
- Pre-sorted in={1,2,3,4,5}, ascending -> out unchanged, `phases`=2, `done` 3 cycles after `start`. Repeat with all elements =9 -> same timing, output all 9.
- Extremes in={255,0,255,0,128}, ascending -> out={0,0,128,255,255}. Pulse `start` again during `busy` with other data -> ignored, result and timing unaffected.
- Assert `rst` 2 cycles into a sort -> no `done`, `out_data`=0, `phases`=0, `busy`=0 next cycle. A new `start` then completes normally.
- Random regression with N=8, WIDTH=16, 1000 vectors in both orders: each output matches a reference sort, `phases` ≤ 8, and `done` latency equals `phases`+1.

Source files
------------

// File: rtl/oddeven_sort_engine.sv
// Odd-even transposition sorter, one compare-swap phase per cycle; done/busy handshake.
// Latency k+1 cycles after accepted start (2 <= k <= N phases); start is ignored while busy.
module oddeven_sort_engine #(
  parameter int WIDTH = 8,
  parameter int N     = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_descending,
  input  logic [N*WIDTH-1:0]      i_in_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [N*WIDTH-1:0]      o_out_data,
  output logic [$clog2(N+1)-1:0]  o_phases
);

  localparam int PW = $clog2(N+1);

  typedef enum logic [1:0] {S_IDLE, S_SORT, S_FINISH} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a     [N];
  logic [WIDTH-1:0]   w_a_nxt [N];
  logic               r_desc;
  logic               r_prev_clean;
  logic [PW-1:0]      r_pcnt;
  logic [PW-1:0]      w_pcnt_nxt;
  logic               w_clean;
  logic               w_exit;
  logic               w_busy;
  logic               w_done;
  logic [N*WIDTH-1:0] r_out_data;
  logic [PW-1:0]      r_phases;

  // Pairs start at index 0 on even phases and index 1 on odd phases; pairs never overlap.
  always_comb begin
    w_a_nxt = r_a;
    w_clean = 1'b1;
    for (int i = 0; i < N-1; i++) begin
      if ((i % 2) == int'(r_pcnt[0])) begin
        if (r_desc ? (r_a[i] < r_a[i+1]) : (r_a[i] > r_a[i+1])) begin
          w_a_nxt[i]   = r_a[i+1];
          w_a_nxt[i+1] = r_a[i];
          w_clean      = 1'b0;
        end
      end
    end
  end

  assign w_pcnt_nxt = r_pcnt + PW'(1);
  assign w_exit     = (w_clean && r_prev_clean) || (w_pcnt_nxt == PW'(N));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_SORT;
      end
      S_SORT: begin
        w_busy = 1'b1;
        if (w_exit) w_state_nxt = S_FINISH;
      end
      S_FINISH: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers load on the final phase edge so they are valid in the FINISH cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N; i++) r_a[i] <= '0;
      r_desc       <= 1'b0;
      r_prev_clean <= 1'b0;
      r_pcnt       <= '0;
      r_out_data   <= '0;
      r_phases     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            for (int i = 0; i < N; i++) r_a[i] <= i_in_data[i*WIDTH +: WIDTH];
            r_desc       <= i_descending;
            r_prev_clean <= 1'b0;
            r_pcnt       <= '0;
          end
        end
        S_SORT: begin
          r_a          <= w_a_nxt;
          r_pcnt       <= w_pcnt_nxt;
          r_prev_clean <= w_clean;
          if (w_exit) begin
            for (int i = 0; i < N; i++) r_out_data[i*WIDTH +: WIDTH] <= w_a_nxt[i];
            r_phases <= w_pcnt_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy     = w_busy;
  assign o_done     = w_done;
  assign o_out_data = r_out_data;
  assign o_phases   = r_phases;

endmodule

// File: tb/tb_oddeven_sort_engine.sv
// Bench for oddeven_sort_engine: directed N=5 cases plus a randomized N=8/WIDTH=16 regression
// checked against a queue-sort reference.
module tb_oddeven_sort_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start5 = 1'b0;
  logic         start8 = 1'b0;
  logic         desc = 1'b0;
  logic [127:0] data = '0;

  logic         busy5, done5, busy8, done8;
  logic [39:0]  out5;
  logic [127:0] out8;
  logic [2:0]   ph5;
  logic [3:0]   ph8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  oddeven_sort_engine #(.WIDTH(8), .N(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_start(start5), .i_descending(desc),
    .i_in_data(data[39:0]), .o_busy(busy5), .o_done(done5),
    .o_out_data(out5), .o_phases(ph5)
  );

  oddeven_sort_engine #(.WIDTH(16), .N(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_descending(desc),
    .i_in_data(data), .o_busy(busy8), .o_done(done8),
    .o_out_data(out8), .o_phases(ph8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack5(input int e0, input int e1, input int e2,
                                         input int e3, input int e4);
    return {88'd0, 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // Runs one sort; lat counts cycles from the accepting edge until done is seen.
  // A nonzero poke_at re-asserts start with different data/order in that busy cycle.
  task automatic run(input string tag, input bit sel, input logic [127:0] din, input bit d,
                     input int poke_at, output logic [127:0] out, output int ph, output int lat);
    data = din;
    desc = d;
    if (sel) start8 = 1'b1; else start5 = 1'b1;
    tick();
    start5 = 1'b0;
    start8 = 1'b0;
    lat = 1;
    while (!(sel ? done8 : done5) && lat < 40) begin
      if (lat == poke_at) begin
        data = ~din;
        desc = ~d;
        if (sel) start8 = 1'b1; else start5 = 1'b1;
      end else begin
        start5 = 1'b0;
        start8 = 1'b0;
      end
      tick();
      lat++;
    end
    start5 = 1'b0;
    start8 = 1'b0;
    if (lat >= 40) check({tag, "_timeout"}, 128'(sel ? done8 : done5), 128'd1);
    out = sel ? out8 : {88'd0, out5};
    ph  = sel ? int'(ph8) : int'(ph5);
    tick();
    check({tag, "_done_pulse"}, 128'(sel ? done8 : done5), 128'd0);
    check({tag, "_busy_drop"},  128'(sel ? busy8 : busy5), 128'd0);
  endtask

  initial begin
    logic [127:0] out;
    logic [127:0] exp;
    int ph, lat, seen;
    int q[$];

    repeat (3) tick();
    check("rst_busy5", 128'(busy5), 128'd0);
    check("rst_done5", 128'(done5), 128'd0);
    check("rst_out5",  128'(out5),  128'd0);
    check("rst_ph5",   128'(ph5),   128'd0);
    check("rst_busy8", 128'(busy8), 128'd0);
    check("rst_out8",  out8,        128'd0);
    rst = 1'b0;
    tick();

    run("asc", 0, pack5(16, 14, 15, 17, 12), 0, 0, out, ph, lat);
    check("asc_out", out, pack5(12, 14, 15, 16, 17));
    check("asc_ph",  128'(ph),  128'd5);
    check("asc_lat", 128'(lat), 128'd6);

    run("desc", 0, pack5(16, 14, 15, 17, 12), 1, 0, out, ph, lat);
    check("desc_out", out, pack5(17, 16, 15, 14, 12));
    check("desc_ph",  128'(ph),  128'd5);
    check("desc_lat", 128'(lat), 128'd6);

    run("sorted", 0, pack5(1, 2, 3, 4, 5), 0, 0, out, ph, lat);
    check("sorted_out", out, pack5(1, 2, 3, 4, 5));
    check("sorted_ph",  128'(ph),  128'd2);
    check("sorted_lat", 128'(lat), 128'd3);

    run("equal", 0, pack5(9, 9, 9, 9, 9), 1, 0, out, ph, lat);
    check("equal_out", out, pack5(9, 9, 9, 9, 9));
    check("equal_ph",  128'(ph),  128'd2);
    check("equal_lat", 128'(lat), 128'd3);

    run("extreme", 0, pack5(255, 0, 255, 0, 128), 0, 2, out, ph, lat);
    check("extreme_out", out, pack5(0, 0, 128, 255, 255));
    check("extreme_ph",  128'(ph),  128'd5);
    check("extreme_lat", 128'(lat), 128'd6);

    // Reset two cycles into a sort.
    data   = pack5(5, 4, 3, 2, 1);
    desc   = 1'b0;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 128'(busy5), 128'd0);
    check("abort_done", 128'(done5), 128'd0);
    check("abort_out",  128'(out5),  128'd0);
    check("abort_ph",   128'(ph5),   128'd0);
    seen = 0;
    repeat (8) begin
      tick();
      if (done5) seen = 1;
    end
    check("abort_no_done", 128'(seen), 128'd0);

    run("after_abort", 0, pack5(16, 14, 15, 17, 12), 0, 0, out, ph, lat);
    check("after_abort_out", out, pack5(12, 14, 15, 16, 17));
    check("after_abort_lat", 128'(lat), 128'd6);

    // Reset and start together: reset wins.
    rst    = 1'b1;
    start5 = 1'b1;
    tick();
    rst    = 1'b0;
    start5 = 1'b0;
    check("rst_start_busy", 128'(busy5), 128'd0);
    check("rst_start_out",  128'(out5),  128'd0);
    tick();

    for (int v = 0; v < 1000; v++) begin
      logic [127:0] din;
      int vals[8];
      for (int i = 0; i < 8; i++) begin
        vals[i] = (v % 4 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
        din[i*16 +: 16] = 16'(vals[i]);
      end
      for (int d = 0; d < 2; d++) begin
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(vals[i]);
        if (d == 1) q.rsort(); else q.sort();
        for (int i = 0; i < 8; i++) exp[i*16 +: 16] = 16'(q[i]);
        run("rnd", 1, din, d[0], 0, out, ph, lat);
        check("rnd_out", out, exp);
        check("rnd_ph_range", 128'(ph >= 2 && ph <= 8), 128'd1);
        check("rnd_lat", 128'(lat), 128'(ph + 1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
